// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: sequences one div/mod request from EXE through the signed or
// unsigned AXI-stream divider IP, holds the selected half of the result until
// EXE consumes it, and drains in-flight IP work when the pipeline flushes.
// Optional build macro: DIV_ZERO_BYPASS_EN (zero divisor answered locally).
module div_issue_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        req_ready,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_result,
  input  logic        resp_ready,
  output logic [63:0] s_div_data,
  output logic        s_sdiv_dvsr_valid,
  input  logic        s_sdiv_dvsr_ready,
  output logic        s_sdiv_dvnd_valid,
  input  logic        s_sdiv_dvnd_ready,
  input  logic        m_sdiv_valid,
  input  logic [63:0] m_sdiv_data,
  output logic        s_udiv_dvsr_valid,
  input  logic        s_udiv_dvsr_ready,
  output logic        s_udiv_dvnd_valid,
  input  logic        s_udiv_dvnd_ready,
  input  logic        m_udiv_valid,
  input  logic [63:0] m_udiv_data,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]    state_q, state_d;
  logic          sel_signed_q, sel_signed_d;
  logic          is_div_q, is_div_d;
  logic          dvsr_taken_q, dvsr_taken_d;
  logic          dvnd_taken_q, dvnd_taken_d;
  logic          dvsr_vld_q, dvsr_vld_d;
  logic          dvnd_vld_q, dvnd_vld_d;
  logic          flush_pend_q, flush_pend_d;
  logic          timeout_err_q, timeout_err_d;
  logic [63:0]   div_data_q, div_data_d;
  logic [31:0]   result_q, result_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          op_onehot_c;
  logic          dvsr_hs_c, dvnd_hs_c;
  logic          dvsr_done_c, dvnd_done_c;
  logic          dout_vld_c;
  logic [63:0]   dout_data_c;

  // Handshake and dout views of whichever IP the latched op selected
  always_comb begin
    op_onehot_c = (req_op != 4'b0) && ((req_op & (req_op - 4'd1)) == 4'b0);
    dvsr_hs_c   = dvsr_vld_q && (sel_signed_q ? s_sdiv_dvsr_ready : s_udiv_dvsr_ready);
    dvnd_hs_c   = dvnd_vld_q && (sel_signed_q ? s_sdiv_dvnd_ready : s_udiv_dvnd_ready);
    dvsr_done_c = dvsr_taken_q || dvsr_hs_c;
    dvnd_done_c = dvnd_taken_q || dvnd_hs_c;
    dout_vld_c  = sel_signed_q ? m_sdiv_valid : m_udiv_valid;
    dout_data_c = sel_signed_q ? m_sdiv_data : m_udiv_data;
  end

  // Next-state and datapath update; flush outranks every other event
  always_comb begin
    state_d       = state_q;
    sel_signed_d  = sel_signed_q;
    is_div_d      = is_div_q;
    dvsr_taken_d  = dvsr_taken_q;
    dvnd_taken_d  = dvnd_taken_q;
    dvsr_vld_d    = dvsr_vld_q;
    dvnd_vld_d    = dvnd_vld_q;
    flush_pend_d  = flush_pend_q;
    timeout_err_d = timeout_err_q;
    div_data_d    = div_data_q;
    result_d      = result_q;
    timer_d       = timer_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && !flush && op_onehot_c) begin
          sel_signed_d = req_op[3] | req_op[2];
          is_div_d     = req_op[3] | req_op[1];
          div_data_d   = {req_src2, req_src1};
`ifdef DIV_ZERO_BYPASS_EN
          if (req_src2 == 32'd0) begin
            state_d  = S_DONE;
            result_d = (req_op[3] | req_op[1]) ? 32'hFFFF_FFFF : req_src1;
          end else
`endif
          begin
            state_d      = S_ISSUE;
            dvsr_vld_d   = 1'b1;
            dvnd_vld_d   = 1'b1;
            dvsr_taken_d = 1'b0;
            dvnd_taken_d = 1'b0;
            flush_pend_d = 1'b0;
          end
        end
      end

      S_ISSUE: begin
        dvsr_taken_d = dvsr_done_c;
        dvnd_taken_d = dvnd_done_c;
        dvsr_vld_d   = !dvsr_done_c;
        dvnd_vld_d   = !dvnd_done_c;
        if (flush && !dvsr_done_c && !dvnd_done_c) begin
          // Nothing reached the IP yet, so it can be abandoned outright
          state_d      = S_IDLE;
          dvsr_vld_d   = 1'b0;
          dvnd_vld_d   = 1'b0;
          dvsr_taken_d = 1'b0;
          dvnd_taken_d = 1'b0;
          flush_pend_d = 1'b0;
        end else begin
          if (flush) begin
            flush_pend_d = 1'b1;
          end
          if (dvsr_done_c && dvnd_done_c) begin
            state_d      = (flush || flush_pend_q) ? S_DRAIN : S_WAIT;
            timer_d      = '0;
            dvsr_taken_d = 1'b0;
            dvnd_taken_d = 1'b0;
            flush_pend_d = 1'b0;
          end
        end
      end

      S_WAIT: begin
        if (flush) begin
          // A dout landing with the flush is swallowed here, no drain needed
          state_d = dout_vld_c ? S_IDLE : S_DRAIN;
        end else if (dout_vld_c) begin
          result_d = is_div_q ? dout_data_c[63:32] : dout_data_c[31:0];
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        if (flush || resp_ready) begin
          state_d = S_IDLE;
        end
      end

      S_DRAIN: begin
        if (dout_vld_c) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d    = S_IDLE;
        dvsr_vld_d = 1'b0;
        dvnd_vld_d = 1'b0;
      end
    endcase

    // Saturating wait counter; error is sticky once a wait reaches the limit
    if (state_q == S_WAIT || state_q == S_DRAIN) begin
      if (timer_q != TW'(TIMEOUT)) begin
        timer_d = timer_q + TW'(1);
      end
      if (timer_q == TW'(TIMEOUT - 1)) begin
        timeout_err_d = 1'b1;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      sel_signed_q  <= 1'b0;
      is_div_q      <= 1'b0;
      dvsr_taken_q  <= 1'b0;
      dvnd_taken_q  <= 1'b0;
      dvsr_vld_q    <= 1'b0;
      dvnd_vld_q    <= 1'b0;
      flush_pend_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      div_data_q    <= '0;
      result_q      <= '0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      sel_signed_q  <= sel_signed_d;
      is_div_q      <= is_div_d;
      dvsr_taken_q  <= dvsr_taken_d;
      dvnd_taken_q  <= dvnd_taken_d;
      dvsr_vld_q    <= dvsr_vld_d;
      dvnd_vld_q    <= dvnd_vld_d;
      flush_pend_q  <= flush_pend_d;
      timeout_err_q <= timeout_err_d;
      div_data_q    <= div_data_d;
      result_q      <= result_d;
      timer_q       <= timer_d;
    end
  end

  assign req_ready         = (state_q == S_IDLE) && !flush;
  assign resp_valid        = (state_q == S_DONE);
  assign resp_result       = result_q;
  assign busy              = (state_q != S_IDLE);
  assign timeout_err       = timeout_err_q;
  assign s_div_data        = div_data_q;
  assign s_sdiv_dvsr_valid = dvsr_vld_q && sel_signed_q;
  assign s_sdiv_dvnd_valid = dvnd_vld_q && sel_signed_q;
  assign s_udiv_dvsr_valid = dvsr_vld_q && !sel_signed_q;
  assign s_udiv_dvnd_valid = dvnd_vld_q && !sel_signed_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: randomized and directed transactions against div_issue_ctrl
// with behavioural divider IPs and a result scoreboard.
module tb_div_issue_ctrl;

  localparam int unsigned TIMEOUT = 64;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        req_ready;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_result;
  logic        resp_ready;
  logic [63:0] s_div_data;
  logic        s_sdiv_dvsr_valid, s_sdiv_dvsr_ready;
  logic        s_sdiv_dvnd_valid, s_sdiv_dvnd_ready;
  logic        m_sdiv_valid;
  logic [63:0] m_sdiv_data;
  logic        s_udiv_dvsr_valid, s_udiv_dvsr_ready;
  logic        s_udiv_dvnd_valid, s_udiv_dvnd_ready;
  logic        m_udiv_valid;
  logic [63:0] m_udiv_data;
  logic        busy;
  logic        timeout_err;

  div_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2),
    .req_ready(req_ready), .flush(flush),
    .resp_valid(resp_valid), .resp_result(resp_result), .resp_ready(resp_ready),
    .s_div_data(s_div_data),
    .s_sdiv_dvsr_valid(s_sdiv_dvsr_valid), .s_sdiv_dvsr_ready(s_sdiv_dvsr_ready),
    .s_sdiv_dvnd_valid(s_sdiv_dvnd_valid), .s_sdiv_dvnd_ready(s_sdiv_dvnd_ready),
    .m_sdiv_valid(m_sdiv_valid), .m_sdiv_data(m_sdiv_data),
    .s_udiv_dvsr_valid(s_udiv_dvsr_valid), .s_udiv_dvsr_ready(s_udiv_dvsr_ready),
    .s_udiv_dvnd_valid(s_udiv_dvnd_valid), .s_udiv_dvnd_ready(s_udiv_dvnd_ready),
    .m_udiv_valid(m_udiv_valid), .m_udiv_data(m_udiv_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction knobs, all relative to k (cycles since the request cycle)
  int k, t_dvsr_dly, t_dvnd_dly, t_lat, t_rr_dly, t_flush_at, rv_cnt;
  int dvsr_cycles, dvnd_cycles;

  // Scoreboard: at most one outstanding op
  logic        pend;
  logic [31:0] pend_res;
  logic        cur_signed;
  logic        byp_txn;

  // Divider IP models: index 0 signed, 1 unsigned
  logic        got_s[2], got_d[2], ip_busy[2];
  logic [31:0] ip_a[2], ip_b[2];
  int          ip_cnt[2];
  logic        hold[4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ip_calc(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 32'd0) return {32'h0, a};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
      sa = a;
      sb = b;
      return {32'(sa / sb), 32'(sa % sb)};
    end
    return {a / b, a % b};
  endfunction

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit is_div, sgn;
    logic [63:0] d;
    is_div = op[3] | op[1];
    sgn    = op[3] | op[2];
`ifdef DIV_ZERO_BYPASS_EN
    if (b == 32'd0) return is_div ? 32'hFFFF_FFFF : a;
`endif
    d = ip_calc(sgn, a, b);
    return is_div ? d[63:32] : d[31:0];
  endfunction

  function automatic bit onehot4(input logic [3:0] v);
    return (v == 4'b1000) || (v == 4'b0100) || (v == 4'b0010) || (v == 4'b0001);
  endfunction

  // One clock cycle: drive at negedge, check, then account for the coming edge
  task automatic step();
    logic [3:0]  tv, tr, forbid;
    logic        mv;
    logic [63:0] md;
    bit          acc;
    for (int i = 0; i < 2; i++) begin
      mv = 1'b0;
      md = '0;
      if (ip_busy[i]) begin
        if (ip_cnt[i] == 0) begin
          mv = 1'b1;
          md = ip_calc(i == 0, ip_a[i], ip_b[i]);
          ip_busy[i] = 1'b0;
        end else begin
          ip_cnt[i]--;
        end
      end
      if (i == 0) begin m_sdiv_valid = mv; m_sdiv_data = md; end
      else begin m_udiv_valid = mv; m_udiv_data = md; end
    end
    s_sdiv_dvsr_ready = (k >= t_dvsr_dly);
    s_udiv_dvsr_ready = (k >= t_dvsr_dly);
    s_sdiv_dvnd_ready = (k >= t_dvnd_dly);
    s_udiv_dvnd_ready = (k >= t_dvnd_dly);
    flush             = (k == t_flush_at);
    resp_ready        = (rv_cnt >= t_rr_dly);
    #1;
    tv = {s_sdiv_dvsr_valid, s_sdiv_dvnd_valid, s_udiv_dvsr_valid, s_udiv_dvnd_valid};
    tr = {s_sdiv_dvsr_ready, s_sdiv_dvnd_ready, s_udiv_dvsr_ready, s_udiv_dvnd_ready};
    for (int i = 0; i < 4; i++)
      if (hold[i]) check("tvalid_hold", 64'(tv[i]), 64'd1);
    forbid = byp_txn ? 4'b1111 : (cur_signed ? 4'b0011 : 4'b1100);
    if (|tv) check("tvalid_select", 64'(tv & forbid), 64'd0);
    if (tv[3] | tv[1]) dvsr_cycles++;
    if (tv[2] | tv[0]) dvnd_cycles++;
    if (resp_valid) begin
      check("resp_expected", 64'(pend), 64'd1);
      check("resp_result", 64'(resp_result), 64'(pend_res));
      check("req_ready_in_done", 64'(req_ready), 64'd0);
    end
    if (req_valid) check("req_ready", 64'(req_ready), 64'(!flush));
    for (int i = 0; i < 4; i++) hold[i] = tv[i] && !tr[i] && !flush;
    // IP captures on handshake
    for (int i = 0; i < 2; i++) begin
      if (tv[3 - 2 * i] && tr[3 - 2 * i]) begin got_s[i] = 1'b1; ip_b[i] = s_div_data[63:32]; end
      if (tv[2 - 2 * i] && tr[2 - 2 * i]) begin got_d[i] = 1'b1; ip_a[i] = s_div_data[31:0]; end
      if (got_s[i] && got_d[i]) begin
        check("ip_overlap", 64'(ip_busy[i]), 64'd0);
        got_s[i] = 1'b0;
        got_d[i] = 1'b0;
        ip_busy[i] = 1'b1;
        ip_cnt[i] = t_lat;
      end
    end
    acc = req_valid && req_ready;
    if (flush) pend = 1'b0;
    if (resp_valid && resp_ready && !flush) pend = 1'b0;
    if (acc && onehot4(req_op)) begin
      pend       = 1'b1;
      pend_res   = ref_result(req_op, req_src1, req_src2);
      cur_signed = req_op[3] | req_op[2];
    end
    if (resp_valid) rv_cnt++;
    @(negedge clk);
    k++;
  endtask

  task automatic run_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int dd, input int nd, input int lat, input int rr, input int fa);
    int n;
    bit vop, byp;
    req_valid = 1'b0;
    n = 0;
    while (busy && n < 600) begin step(); n++; end
    if (busy) check("drain_timeout", 64'(busy), 64'd0);
    t_dvsr_dly = dd; t_dvnd_dly = nd; t_lat = lat; t_rr_dly = rr; t_flush_at = fa;
    k = 0; rv_cnt = 0; dvsr_cycles = 0; dvnd_cycles = 0;
    vop = onehot4(op);
    byp = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
    byp = (b == 32'd0);
`endif
    byp_txn   = byp;
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    step();
    req_valid = 1'b0;
    check("busy_after_req", 64'(busy), 64'(vop && fa != 0));
    if (byp && vop && fa != 0) check("bypass_resp_next", 64'(resp_valid), 64'd1);
    n = 0;
    while ((pend || busy) && n < 600) begin step(); n++; end
    if (pend || busy) check("resp_timeout", 64'({pend, busy}), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_op = 4'b0; req_src1 = '0; req_src2 = '0;
    flush = 1'b0; resp_ready = 1'b0;
    s_sdiv_dvsr_ready = 1'b0; s_sdiv_dvnd_ready = 1'b0; m_sdiv_valid = 1'b0; m_sdiv_data = '0;
    s_udiv_dvsr_ready = 1'b0; s_udiv_dvnd_ready = 1'b0; m_udiv_valid = 1'b0; m_udiv_data = '0;
    pend = 1'b0; pend_res = '0; cur_signed = 1'b0; byp_txn = 1'b0;
    k = 0; t_dvsr_dly = 0; t_dvnd_dly = 0; t_lat = 0; t_rr_dly = 0; t_flush_at = -1; rv_cnt = 0;
    dvsr_cycles = 0; dvnd_cycles = 0;
    for (int i = 0; i < 2; i++) begin
      got_s[i] = 1'b0; got_d[i] = 1'b0; ip_busy[i] = 1'b0; ip_a[i] = '0; ip_b[i] = '0; ip_cnt[i] = 0;
    end
    for (int i = 0; i < 4; i++) hold[i] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_busy", 64'(busy), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_result", 64'(resp_result), 64'd0);
    check("rst_div_data", s_div_data, 64'd0);
    check("rst_tvalids", 64'({s_sdiv_dvsr_valid, s_sdiv_dvnd_valid, s_udiv_dvsr_valid, s_udiv_dvnd_valid}), 64'd0);
    check("rst_timeout", 64'(timeout_err), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);

    // div_w 100/7, IP always ready: one-cycle issue
    run_txn(4'b1000, 32'd100, 32'd7, 0, 0, 33, 0, -1);
    check("t1_dvsr_cycles", 64'(dvsr_cycles), 64'd1);
    check("t1_dvnd_cycles", 64'(dvnd_cycles), 64'd1);
    // mod_wu 0xFFFFFFFF % 10 with the dividend channel accepted three cycles late
    run_txn(4'b0001, 32'hFFFF_FFFF, 32'd10, 1, 4, 20, 0, -1);
    check("t2_dvsr_cycles", 64'(dvsr_cycles), 64'd1);
    check("t2_dvnd_cycles", 64'(dvnd_cycles), 64'd4);
    // div_w -7/2 with EXE stalling the result for five cycles
    run_txn(4'b1000, 32'hFFFF_FFF9, 32'd2, 0, 0, 10, 5, -1);
    check("t3_resp_hold", 64'(rv_cnt), 64'd6);
    // flush ten cycles into WAIT
    run_txn(4'b1000, 32'd1000, 32'd3, 1, 1, 40, 0, 12);
    check("t4_no_resp", 64'(rv_cnt), 64'd0);
    // flush in ISSUE after only the divisor was taken, then a clean div_wu 9/3
    run_txn(4'b1000, 32'd77, 32'd5, 1, 6, 15, 0, 3);
    check("t5_no_resp", 64'(rv_cnt), 64'd0);
    run_txn(4'b0010, 32'd9, 32'd3, 0, 0, 5, 0, -1);
    // zero divisors
    run_txn(4'b1000, 32'd5, 32'd0, 0, 0, 8, 0, -1);
    run_txn(4'b0100, 32'd5, 32'd0, 0, 0, 8, 0, -1);
    // non-one-hot op and a request under flush are both refused
    run_txn(4'b0011, 32'd5, 32'd1, 0, 0, 8, 0, -1);
    run_txn(4'b1000, 32'd5, 32'd1, 0, 0, 8, 0, 0);
    // flush while the result is held
    run_txn(4'b0100, 32'd50, 32'd7, 0, 0, 2, 20, 9);

    for (int t = 0; t < 80; t++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      int lat, fa;
      case ($urandom % 4)
        0: op = 4'b1000;
        1: op = 4'b0100;
        2: op = 4'b0010;
        default: op = 4'b0001;
      endcase
      if ($urandom % 12 == 0) op = 4'($urandom);
      a = $urandom;
      case ($urandom % 8)
        0: b = 32'd0;
        1, 2: b = 32'($urandom_range(1, 9));
        3: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      lat = $urandom_range(0, 30);
      fa = ($urandom % 4 == 0) ? $urandom_range(1, lat + 12) : -1;
      run_txn(op, a, b, $urandom_range(0, 4), $urandom_range(0, 4), lat, $urandom_range(0, 3), fa);
    end
    check("no_timeout_yet", 64'(timeout_err), 64'd0);

    // IP stalls well past the wait limit
    run_txn(4'b0010, 32'd40, 32'd8, 0, 0, 90, 0, -1);
    check("timeout_sticky", 64'(timeout_err), 64'd1);
    run_txn(4'b1000, 32'd40, 32'd8, 0, 0, 3, 0, -1);
    check("timeout_still_set", 64'(timeout_err), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
